// File: rtl/vga_timing_controller.sv
// 640x480@60 VGA scan generator: drives row/col to the drawers, registers their RGB onto the pins.
// Define VGA_TEST_PATTERN_EN to add the built-in colour-bar generator selected by test_pattern.
module vga_timing_controller #(
    parameter int   CLK_DIV     = 2,
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output int         col,
    output int         row,
    input  logic [3:0] in_red,
    input  logic [3:0] in_green,
    input  logic [3:0] in_blue,
    input  logic       test_pattern,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       hsync,
    output logic       vsync,
    output logic       visible,
    output logic       frame_start
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0] div;
    logic       pix_en;
    logic       line_end;
    logic       frame_end;
    logic       h_active;
    logic       v_active;
    logic [3:0] pix_red;
    logic [3:0] pix_green;
    logic [3:0] pix_blue;

    // With CLK_DIV = 1 DIV_LAST is 0, so div never leaves 0 and pix_en stays high.
    assign pix_en    = (div == DIV_LAST);
    assign line_end  = (col == H_TOTAL - 1);
    assign frame_end = pix_en && line_end && (row == V_TOTAL - 1);
    assign visible   = (col < H_VISIBLE) && (row < V_VISIBLE);
    assign h_active  = (col >= HS_START) && (col < HS_END);
    assign v_active  = (row >= VS_START) && (row < VS_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            div <= 4'd0;
        end else if (pix_en) begin
            div <= 4'd0;
        end else begin
            div <= div + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col <= 0;
            row <= 0;
        end else if (pix_en) begin
            if (line_end) begin
                col <= 0;
                row <= (row == V_TOTAL - 1) ? 0 : row + 1;
            end else begin
                col <= col + 1;
            end
        end
    end

    // Registered from the wrap itself, so it is high exactly while the counters first read (0,0).
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_end;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_VISIBLE / 8;

    logic [2:0] bar;

    assign bar = 3'(col / BAR_W);

    // Bar order white, yellow, cyan, green, magenta, red, blue, black falls out of the index bits.
    always_comb begin
        pix_red   = in_red;
        pix_green = in_green;
        pix_blue  = in_blue;
        if (test_pattern) begin
            pix_red   = {4{~bar[1]}};
            pix_green = {4{~bar[2]}};
            pix_blue  = {4{~bar[0]}};
        end
    end
`else
    logic unused_test_pattern;

    assign unused_test_pattern = test_pattern;
    assign pix_red             = in_red;
    assign pix_green           = in_green;
    assign pix_blue            = in_blue;
`endif

    // Pins use the pre-increment counters, so they lag row/col by one pixel period.
    always_ff @(posedge clk) begin
        if (reset) begin
            red   <= 4'd0;
            green <= 4'd0;
            blue  <= 4'd0;
            hsync <= ~SYNC_ACTIVE;
            vsync <= ~SYNC_ACTIVE;
        end else if (pix_en) begin
            red   <= visible ? pix_red   : 4'd0;
            green <= visible ? pix_green : 4'd0;
            blue  <= visible ? pix_blue  : 4'd0;
            hsync <= h_active ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync <= v_active ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

endmodule
